// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared types and resolution constants for the VGA plot arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

`ifdef VGA_640_480
    localparam int c_VGA_N    = 10;
    localparam int c_VGA_COLS = 640;
    localparam int c_VGA_ROWS = 480;
`elsif VGA_320_240
    localparam int c_VGA_N    = 9;
    localparam int c_VGA_COLS = 320;
    localparam int c_VGA_ROWS = 240;
`else
    localparam int c_VGA_N    = 8;
    localparam int c_VGA_COLS = 160;
    localparam int c_VGA_ROWS = 120;
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef logic [2:0] color_t;

    function automatic int ptr_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_plot_arbiter_rr.sv
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin grant search starting at ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]            req,
    input  logic [ptr_width(NREQ)-1:0] ptr,
    input  logic                       enable,
    output logic [NREQ-1:0]            gnt,
    output logic [ptr_width(NREQ)-1:0] next_ptr
);

    localparam int PW = ptr_width(NREQ);

    logic w_found;
    int   w_idx;

    // First asserted request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(ptr) + k) % NREQ;
            if (enable && !w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                next_ptr   = PW'((w_idx + 1) % NREQ);
                w_found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
// ============================================================================
// Module  : vga_plot_arbiter
// Purpose : Shares the VGA pixel-write port among NREQ producers, with a
//           built-in clear-screen sweep that has priority over requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int     NREQ     = 4,
    parameter int     n        = c_VGA_N,
    parameter int     COLS     = c_VGA_COLS,
    parameter int     ROWS     = c_VGA_ROWS,
    parameter color_t BG_COLOR = 3'd0
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*n-1:0]     req_x,
    input  logic [NREQ*(n-1)-1:0] req_y,
    input  logic [NREQ*3-1:0]     req_color,
    output logic [NREQ-1:0]       gnt,
    input  logic                  clear,
    output logic                  clear_busy,
    output logic [n-1:0]          VGA_X,
    output logic [n-2:0]          VGA_Y,
    output color_t                VGA_COLOR,
    output logic                  plot
);

    localparam int            PW       = ptr_width(NREQ);
    localparam logic [n-1:0]  c_LAST_X = n'(COLS - 1);
    localparam logic [n-2:0]  c_LAST_Y = (n-1)'(ROWS - 1);

    state_t          r_state;
    state_t          w_next_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_next_ptr;
    logic [n-1:0]    r_cx;
    logic [n-2:0]    r_cy;
    logic            w_arb_en;
    logic            w_last;
    logic            w_xfer;
    logic            w_in_range;

    logic [n-1:0]    w_x [NREQ];
    logic [n-2:0]    w_y [NREQ];
    color_t          w_c [NREQ];
    logic [n-1:0]    w_sel_x;
    logic [n-2:0]    w_sel_y;
    color_t          w_sel_c;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_x[gi] = req_x[gi*n +: n];
            assign w_y[gi] = req_y[gi*(n-1) +: (n-1)];
            assign w_c[gi] = req_color[gi*3 +: 3];
        end
    endgenerate

    rr_arbiter #(
        .NREQ     (NREQ)
    ) u_rr (
        .req      (req),
        .ptr      (r_ptr),
        .enable   (w_arb_en),
        .gnt      (gnt),
        .next_ptr (w_next_ptr)
    );

    // gnt is one-hot, so an OR of the masked fields is the selected pixel.
    always_comb begin
        w_sel_x = '0;
        w_sel_y = '0;
        w_sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                w_sel_x = w_sel_x | w_x[i];
                w_sel_y = w_sel_y | w_y[i];
                w_sel_c = w_sel_c | w_c[i];
            end
        end
    end

    assign w_xfer     = |(req & gnt);
    assign w_in_range = (32'(w_sel_x) < COLS) && (32'(w_sel_y) < ROWS);
    assign w_last     = (r_cx == c_LAST_X) && (r_cy == c_LAST_Y);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (clear)  w_next_state = CLEAR;
            CLEAR:   if (w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        clear_busy = (r_state == CLEAR);
        w_arb_en   = resetn && (r_state == IDLE) && !clear;
    end

    // Out-of-range pixels still advance the pointer but leave the outputs alone.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_ptr     <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
            plot      <= 1'b0;
        end else if (r_state == CLEAR) begin
            VGA_X     <= r_cx;
            VGA_Y     <= r_cy;
            VGA_COLOR <= BG_COLOR;
            plot      <= 1'b1;
            if (r_cx == c_LAST_X) begin
                r_cx <= '0;
                r_cy <= w_last ? '0 : r_cy + (n-1)'(1);
            end else begin
                r_cx <= r_cx + n'(1);
            end
        end else begin
            plot <= 1'b0;
            if (clear) begin
                r_cx <= '0;
                r_cy <= '0;
            end
            if (w_xfer) begin
                r_ptr <= w_next_ptr;
                if (w_in_range) begin
                    VGA_X     <= w_sel_x;
                    VGA_Y     <= w_sel_y;
                    VGA_COLOR <= w_sel_c;
                    plot      <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
// ============================================================================
// Module  : tb_vga_plot_arbiter
// Purpose : Self-checking bench for vga_plot_arbiter (model + directed vectors).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_plot_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int COLS = 160;
    localparam int ROWS = 120;
    localparam int CR   = COLS * ROWS;

    logic                  CLOCK_50 = 1'b0;
    logic                  resetn   = 1'b0;
    logic [NREQ-1:0]       req      = '0;
    logic [NREQ*N-1:0]     req_x    = '0;
    logic [NREQ*(N-1)-1:0] req_y    = '0;
    logic [NREQ*3-1:0]     req_color = '0;
    logic                  clear    = 1'b0;
    logic [NREQ-1:0]       gnt;
    logic                  clear_busy;
    logic [N-1:0]          VGA_X;
    logic [N-2:0]          VGA_Y;
    logic [2:0]            VGA_COLOR;
    logic                  plot;

    vga_plot_arbiter #(
        .NREQ      (NREQ),
        .n         (N),
        .COLS      (COLS),
        .ROWS      (ROWS),
        .BG_COLOR  (3'd0)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .req       (req),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .gnt       (gnt),
        .clear     (clear),
        .clear_busy(clear_busy),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: sweep as a linear pixel index, grant as a wrapped search.
    int m_ptr  = 0;
    bit m_busy = 1'b0;
    int m_idx  = 0;
    int e_x = 0, e_y = 0, e_c = 0;
    bit e_plot = 1'b0;
    int m_p, m_px, m_py, m_pc, c_p;

    function automatic int model_pick();
        int i;
        if (!resetn || m_busy || clear) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    always @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            m_ptr = 0; m_busy = 0; m_idx = 0;
            e_x = 0; e_y = 0; e_c = 0; e_plot = 0;
        end else if (m_busy) begin
            e_x = m_idx % COLS;
            e_y = m_idx / COLS;
            e_c = 0;
            e_plot = 1;
            m_idx++;
            if (m_idx == CR) m_busy = 0;
        end else begin
            m_p = model_pick();
            e_plot = 0;
            if (clear) begin
                m_busy = 1;
                m_idx  = 0;
            end else if (m_p >= 0) begin
                m_ptr = (m_p + 1) % NREQ;
                m_px = int'(req_x[m_p*N +: N]);
                m_py = int'(req_y[m_p*(N-1) +: (N-1)]);
                m_pc = int'(req_color[m_p*3 +: 3]);
                if (m_px < COLS && m_py < ROWS) begin
                    e_x = m_px; e_y = m_py; e_c = m_pc; e_plot = 1;
                end
            end
        end
    end

    always @(negedge CLOCK_50) begin
        c_p = model_pick();
        chk("gnt", 32'(gnt), (c_p < 0) ? 32'd0 : (32'd1 << c_p));
        chk("outputs", 32'({VGA_X, VGA_Y, VGA_COLOR, plot, clear_busy}),
            32'({e_x[7:0], e_y[6:0], e_c[2:0], e_plot, m_busy}));
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_req(input int i, input int x, input int y, input int c);
        req_x[i*N +: N]           = x[N-1:0];
        req_y[i*(N-1) +: (N-1)]   = y[N-2:0];
        req_color[i*3 +: 3]       = c[2:0];
    endtask

    task automatic do_reset();
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    int bc, pc, gh, oe, nc, lx, ly;
    bit found;

    initial begin
        req = 4'hF;
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        repeat (2) tick();
        req    = '0;
        resetn = 1'b1;
        @(negedge CLOCK_50);
        chk("rst_out", 32'({VGA_X, VGA_Y, VGA_COLOR, plot, clear_busy}), 32'd0);

        // single pixel from requester 0
        tick();
        set_req(0, 5, 7, 3);
        req = 4'b0001;
        @(negedge CLOCK_50);
        chk("t1_gnt", 32'(gnt), 32'b0001);
        tick();
        req = '0;
        @(negedge CLOCK_50);
        chk("t1_pix", 32'({VGA_X, VGA_Y, VGA_COLOR, plot}), 32'({8'd5, 7'd7, 3'd3, 1'b1}));
        tick();
        @(negedge CLOCK_50);
        chk("t1_idle", 32'({VGA_X, plot}), 32'({8'd5, 1'b0}));

        // all four requesting for eight cycles from a fresh pointer
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, 20 + i, i);
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK_50);
            chk("t2_gnt", 32'(gnt), 32'd1 << (k % 4));
            if (k > 0) chk("t2_plot", 32'({VGA_X, plot}), 32'(((10 + (k - 1) % 4) << 1) | 1));
            tick();
        end
        req = '0;
        @(negedge CLOCK_50);
        chk("t2_last", 32'({VGA_X, VGA_Y, VGA_COLOR, plot}), 32'({8'd13, 7'd23, 3'd3, 1'b1}));

        // out-of-range x is consumed but not plotted
        tick();
        set_req(2, 160, 5, 7);
        req = 4'b0100;
        @(negedge CLOCK_50);
        chk("t3_gnt", 32'(gnt), 32'b0100);
        tick();
        req = '0;
        @(negedge CLOCK_50);
        chk("t3_drop", 32'({VGA_X, VGA_Y, VGA_COLOR, plot}), 32'({8'd13, 7'd23, 3'd3, 1'b0}));

        // full clear sweep with all requesters pending
        tick();
        req   = 4'hF;
        clear = 1'b1;
        @(negedge CLOCK_50);
        chk("t4_gnt_clear", 32'(gnt), 32'd0);
        tick();
        clear = 1'b0;
        bc = 0; pc = 0; gh = 0; oe = 0; nc = 0; lx = -1; ly = -1;
        do begin
            @(negedge CLOCK_50);
            nc++;
            if (clear_busy) begin
                bc++;
                if (gnt != '0) gh++;
            end
            if (plot) begin
                if (int'(VGA_X) != pc % COLS || int'(VGA_Y) != pc / COLS || VGA_COLOR != 3'd0) oe++;
                pc++;
                lx = int'(VGA_X);
                ly = int'(VGA_Y);
            end
        end while (clear_busy && nc < CR + 10);
        chk("t4_busy_cycles", 32'(bc), 32'(CR));
        chk("t4_plots", 32'(pc), 32'(CR));
        chk("t4_last_x", 32'(lx), 32'd159);
        chk("t4_last_y", 32'(ly), 32'd119);
        chk("t4_gnt_quiet", 32'(gh), 32'd0);
        chk("t4_order", 32'(oe), 32'd0);
        tick();
        req = '0;

        // clear and a request in the same cycle
        tick();
        set_req(1, 50, 60, 5);
        req   = 4'b0010;
        clear = 1'b1;
        @(negedge CLOCK_50);
        chk("t5_gnt0", 32'(gnt), 32'd0);
        tick();
        clear = 1'b0;
        nc = 0; gh = 0;
        do begin
            @(negedge CLOCK_50);
            nc++;
            if (clear_busy && gnt != '0) gh++;
        end while (clear_busy && nc < CR + 10);
        chk("t5_busy_end", 32'(clear_busy), 32'd0);
        chk("t5_quiet", 32'(gh), 32'd0);
        chk("t5_gnt_after", 32'(gnt), 32'b0010);
        tick();
        req = '0;
        @(negedge CLOCK_50);
        chk("t5_pix", 32'({VGA_X, VGA_Y, VGA_COLOR, plot}), 32'({8'd50, 7'd60, 3'd5, 1'b1}));

        // reset in the middle of a sweep, then restart
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        nc = 0; found = 1'b0;
        while (!found && nc < 2000) begin
            @(negedge CLOCK_50);
            nc++;
            if (plot && VGA_X == 8'd40 && VGA_Y == 7'd3) found = 1'b1;
        end
        chk("t6_reach", 32'(found), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst", 32'({VGA_X, VGA_Y, VGA_COLOR, plot, clear_busy, gnt}), 32'd0);
        tick();
        resetn = 1'b1;
        clear  = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge CLOCK_50);
        chk("t6_busy", 32'({clear_busy, plot}), 32'b10);
        @(negedge CLOCK_50);
        chk("t6_restart", 32'({VGA_X, VGA_Y, VGA_COLOR, plot}), 32'({8'd0, 7'd0, 3'd0, 1'b1}));
        @(negedge CLOCK_50);
        chk("t6_second", 32'({VGA_X, VGA_Y, plot}), 32'({8'd1, 7'd0, 1'b1}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
